// File: rtl/flash_sample_reader.sv
// rtl/flash_sample_reader.sv - fetches one flash word per request and plays it out as two audio samples
//
// Ports:
//   clk, reset_n            single clock, asynchronous active-low reset
//   start_flash             read request level from the address sequencer (rising edge launches)
//   flash_mem_address       word address from the sequencer (low ADDR_WIDTH bits used)
//   sample_tick             one-cycle strobe at the audio sample rate
//   flash_*                 Avalon-MM read master towards the flash controller
//   audio_data/audio_valid  current sample and its one-cycle update strobe
//   audio_done              one-cycle pulse once both halves of the word have been presented
//   busy                    high whenever a request is in progress
module flash_sample_reader #(
    parameter int ADDR_WIDTH   = 23,
    parameter int DATA_WIDTH   = 32,
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start_flash,
    input  logic [31:0]             flash_mem_address,
    input  logic                    sample_tick,
    output logic                    flash_read,
    output logic [ADDR_WIDTH-1:0]   flash_address,
    output logic [3:0]              flash_byteenable,
    input  logic                    flash_waitrequest,
    input  logic [DATA_WIDTH-1:0]   flash_readdata,
    input  logic                    flash_readdatavalid,
    output logic [SAMPLE_WIDTH-1:0] audio_data,
    output logic                    audio_valid,
    output logic                    audio_done,
    output logic                    busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_DATA,
        S_WAIT_LO,
        S_WAIT_HI,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_start_q;
    logic [ADDR_WIDTH-1:0]   r_flash_address;
    logic [DATA_WIDTH-1:0]   r_word;
    logic [SAMPLE_WIDTH-1:0] r_audio_data;
    logic                    r_audio_valid;
    logic                    r_audio_done;

    logic                    w_launch;
    logic                    w_latch_addr;
    logic                    w_latch_word;
    logic                    w_load_lo;
    logic                    w_load_hi;

    // Upper address bits belong to the sequencer's address space only.
    logic                    w_unused_addr_hi;
    assign w_unused_addr_hi = ^flash_mem_address[31:ADDR_WIDTH];

    // Launches outside IDLE are simply lost; the sequencer never relies on queuing.
    assign w_launch = start_flash & ~r_start_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_latch_addr = 1'b0;
        w_latch_word = 1'b0;
        w_load_lo    = 1'b0;
        w_load_hi    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_latch_addr = 1'b1;
                    w_next       = S_REQ;
                end
            end
            S_REQ: begin
                // Command accepted; the controller may return data in the same cycle.
                if (!flash_waitrequest) begin
                    if (flash_readdatavalid) begin
                        w_latch_word = 1'b1;
                        w_next       = S_WAIT_LO;
                    end else begin
                        w_next = S_WAIT_DATA;
                    end
                end
            end
            S_WAIT_DATA: begin
                if (flash_readdatavalid) begin
                    w_latch_word = 1'b1;
                    w_next       = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (sample_tick) begin
                    w_load_lo = 1'b1;
                    w_next    = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (sample_tick) begin
                    w_load_hi = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_start_q       <= 1'b0;
            r_flash_address <= '0;
            r_word          <= '0;
            r_audio_data    <= '0;
            r_audio_valid   <= 1'b0;
            r_audio_done    <= 1'b0;
        end else begin
            r_start_q     <= start_flash;
            r_audio_valid <= w_load_lo | w_load_hi;
            // Registered off DONE so the pulse lands the cycle after the high-half strobe.
            r_audio_done  <= (r_state == S_DONE);
            if (w_latch_addr) begin
                r_flash_address <= flash_mem_address[ADDR_WIDTH-1:0];
            end
            if (w_latch_word) begin
                r_word <= flash_readdata;
            end
            if (w_load_lo) begin
                r_audio_data <= r_word[SAMPLE_WIDTH-1:0];
            end else if (w_load_hi) begin
                r_audio_data <= r_word[DATA_WIDTH-1:SAMPLE_WIDTH];
            end
        end
    end

    assign flash_read       = (r_state == S_REQ);
    assign flash_address    = r_flash_address;
    assign flash_byteenable = 4'b1111;
    assign audio_data       = r_audio_data;
    assign audio_valid      = r_audio_valid;
    assign audio_done       = r_audio_done;
    assign busy             = (r_state != S_IDLE);

endmodule

// File: tb/tb_flash_sample_reader.sv
// tb/tb_flash_sample_reader.sv - directed self-checking bench for flash_sample_reader
module tb_flash_sample_reader;

    logic        clk;
    logic        reset_n;
    logic        start_flash;
    logic [31:0] flash_mem_address;
    logic        sample_tick;
    logic        flash_read;
    logic [22:0] flash_address;
    logic [3:0]  flash_byteenable;
    logic        flash_waitrequest;
    logic [31:0] flash_readdata;
    logic        flash_readdatavalid;
    logic [15:0] audio_data;
    logic        audio_valid;
    logic        audio_done;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    int rd_cycles = 0;
    int av_cnt = 0;
    int done_cnt = 0;
    logic [22:0] rd_addr_q[$];
    logic [15:0] samp_q[$];

    flash_sample_reader dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .start_flash         (start_flash),
        .flash_mem_address   (flash_mem_address),
        .sample_tick         (sample_tick),
        .flash_read          (flash_read),
        .flash_address       (flash_address),
        .flash_byteenable    (flash_byteenable),
        .flash_waitrequest   (flash_waitrequest),
        .flash_readdata      (flash_readdata),
        .flash_readdatavalid (flash_readdatavalid),
        .audio_data          (audio_data),
        .audio_valid         (audio_valid),
        .audio_done          (audio_done),
        .busy                (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (flash_read) rd_cycles++;
        if (flash_read && !flash_waitrequest) rd_addr_q.push_back(flash_address);
        if (audio_valid) begin
            av_cnt++;
            samp_q.push_back(audio_data);
        end
        if (audio_done) done_cnt++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start_flash = 1'b0;
        flash_mem_address = '0;
        sample_tick = 1'b0;
        flash_waitrequest = 1'b0;
        flash_readdata = '0;
        flash_readdatavalid = 1'b0;
        cyc();
        cyc();
        if ({flash_read, audio_valid, audio_done, busy} !== 4'b0000) begin
            $display("FAIL reset_ctrl: got %b want 0000", {flash_read, audio_valid, audio_done, busy});
            n_err++;
        end
        n_vec++;
        if (flash_address !== 23'h0 || audio_data !== 16'h0) begin
            $display("FAIL reset_data: addr %h data %h want 0 0", flash_address, audio_data);
            n_err++;
        end
        n_vec++;
        if (flash_byteenable !== 4'hF) begin
            $display("FAIL byteenable: got %h want f", flash_byteenable);
            n_err++;
        end
        n_vec++;
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        int rc0;
        int dn0;
        rc0 = rd_cycles;
        dn0 = done_cnt;
        flash_waitrequest = 1'b0;
        flash_mem_address = 32'h0000_0100;
        start_flash = 1'b1;
        cyc();
        if (flash_read !== 1'b1 || flash_address !== 23'h000100 || busy !== 1'b1) begin
            $display("FAIL basic_req: read %b addr %h busy %b want 1 000100 1", flash_read, flash_address, busy);
            n_err++;
        end
        n_vec++;
        cyc();
        cyc();
        cyc();
        flash_readdata = 32'hBEEF_1234;
        flash_readdatavalid = 1'b1;
        cyc();
        flash_readdatavalid = 1'b0;
        if (rd_cycles - rc0 !== 1) begin
            $display("FAIL basic_read_len: got %0d want 1", rd_cycles - rc0);
            n_err++;
        end
        n_vec++;
        cyc();
        pulse_tick();
        if (audio_valid !== 1'b1 || audio_data !== 16'h1234) begin
            $display("FAIL basic_lo: valid %b data %h want 1 1234", audio_valid, audio_data);
            n_err++;
        end
        n_vec++;
        cyc();
        if (audio_valid !== 1'b0 || audio_data !== 16'h1234) begin
            $display("FAIL basic_hold: valid %b data %h want 0 1234", audio_valid, audio_data);
            n_err++;
        end
        n_vec++;
        pulse_tick();
        if (audio_valid !== 1'b1 || audio_data !== 16'hBEEF || audio_done !== 1'b0) begin
            $display("FAIL basic_hi: valid %b data %h done %b want 1 beef 0", audio_valid, audio_data, audio_done);
            n_err++;
        end
        n_vec++;
        cyc();
        if (audio_done !== 1'b1 || busy !== 1'b0 || audio_valid !== 1'b0) begin
            $display("FAIL basic_done: done %b busy %b valid %b want 1 0 0", audio_done, busy, audio_valid);
            n_err++;
        end
        n_vec++;
        start_flash = 1'b0;
        cyc();
        cyc();
        if (done_cnt - dn0 !== 1) begin
            $display("FAIL basic_done_cnt: got %0d want 1", done_cnt - dn0);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_waitrequest();
        int rc0;
        int sq0;
        rc0 = rd_cycles;
        sq0 = samp_q.size();
        flash_waitrequest = 1'b1;
        flash_mem_address = 32'h0000_0ABC;
        start_flash = 1'b1;
        cyc();
        for (int i = 0; i < 5; i++) begin
            if (flash_read !== 1'b1 || flash_address !== 23'h000ABC) begin
                $display("FAIL stall_hold%0d: read %b addr %h want 1 000abc", i, flash_read, flash_address);
                n_err++;
            end
            n_vec++;
            cyc();
        end
        flash_waitrequest = 1'b0;
        cyc();
        if (rd_cycles - rc0 !== 6) begin
            $display("FAIL stall_read_len: got %0d want 6", rd_cycles - rc0);
            n_err++;
        end
        n_vec++;
        flash_readdata = 32'h00FF_FF00;
        flash_readdatavalid = 1'b1;
        cyc();
        flash_readdatavalid = 1'b0;
        pulse_tick();
        cyc();
        pulse_tick();
        cyc();
        start_flash = 1'b0;
        cyc();
        if (samp_q.size() - sq0 !== 2) begin
            $display("FAIL stall_nsamp: got %0d want 2", samp_q.size() - sq0);
            n_err++;
        end else if (samp_q[sq0] !== 16'hFF00 || samp_q[sq0+1] !== 16'h00FF) begin
            $display("FAIL stall_samples: got %h %h want ff00 00ff", samp_q[sq0], samp_q[sq0+1]);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_same_cycle_valid();
        flash_waitrequest = 1'b0;
        flash_mem_address = 32'h0000_0042;
        start_flash = 1'b1;
        cyc();
        flash_readdata = 32'h5555_AAAA;
        flash_readdatavalid = 1'b1;
        cyc();
        flash_readdatavalid = 1'b0;
        // Already in WAIT_LO: an immediate tick must be honoured.
        pulse_tick();
        if (audio_valid !== 1'b1 || audio_data !== 16'hAAAA) begin
            $display("FAIL same_lo: valid %b data %h want 1 aaaa", audio_valid, audio_data);
            n_err++;
        end
        n_vec++;
        pulse_tick();
        if (audio_valid !== 1'b1 || audio_data !== 16'h5555) begin
            $display("FAIL same_hi: valid %b data %h want 1 5555", audio_valid, audio_data);
            n_err++;
        end
        n_vec++;
        cyc();
        start_flash = 1'b0;
        cyc();
    endtask

    task automatic test_early_ticks();
        int rc0;
        int av0;
        int ra0;
        rc0 = rd_cycles;
        av0 = av_cnt;
        ra0 = rd_addr_q.size();
        flash_waitrequest = 1'b0;
        flash_mem_address = 32'h0000_0200;
        start_flash = 1'b1;
        cyc();
        pulse_tick();
        pulse_tick();
        start_flash = 1'b0;
        cyc();
        start_flash = 1'b1;
        flash_mem_address = 32'h0000_0999;
        cyc();
        flash_readdata = 32'hCAFE_0001;
        flash_readdatavalid = 1'b1;
        sample_tick = 1'b1;
        cyc();
        flash_readdatavalid = 1'b0;
        sample_tick = 1'b0;
        cyc();
        if (av_cnt - av0 !== 0 || audio_data !== 16'h5555) begin
            $display("FAIL early_no_valid: count %0d data %h want 0 5555", av_cnt - av0, audio_data);
            n_err++;
        end
        n_vec++;
        if (rd_cycles - rc0 !== 1 || rd_addr_q.size() - ra0 !== 1 || flash_address !== 23'h000200) begin
            $display("FAIL early_no_relaunch: cycles %0d reads %0d addr %h want 1 1 000200",
                     rd_cycles - rc0, rd_addr_q.size() - ra0, flash_address);
            n_err++;
        end
        n_vec++;
        pulse_tick();
        if (audio_valid !== 1'b1 || audio_data !== 16'h0001) begin
            $display("FAIL early_lo: valid %b data %h want 1 0001", audio_valid, audio_data);
            n_err++;
        end
        n_vec++;
        pulse_tick();
        if (audio_valid !== 1'b1 || audio_data !== 16'hCAFE) begin
            $display("FAIL early_hi: valid %b data %h want 1 cafe", audio_valid, audio_data);
            n_err++;
        end
        n_vec++;
        cyc();
        start_flash = 1'b0;
        cyc();
    endtask

    task automatic test_back_to_back();
        int ra0;
        int sq0;
        int dn0;
        bit seen;
        ra0 = rd_addr_q.size();
        sq0 = samp_q.size();
        dn0 = done_cnt;
        flash_waitrequest = 1'b0;
        for (int k = 0; k < 4; k++) begin
            flash_mem_address = 32'h10 + k;
            start_flash = 1'b1;
            cyc();
            cyc();
            flash_readdata = {16'h1000 + 16'(2 * k + 1), 16'h1000 + 16'(2 * k)};
            flash_readdatavalid = 1'b1;
            cyc();
            flash_readdatavalid = 1'b0;
            seen = 1'b0;
            for (int t = 0; t < 30 && !seen; t++) begin
                sample_tick = (t % 3 == 0);
                cyc();
                sample_tick = 1'b0;
                if (audio_done) seen = 1'b1;
            end
            if (!seen) begin
                $display("FAIL loop_timeout%0d: audio_done 0 want 1 within 30 cycles", k);
                n_err++;
            end
            n_vec++;
            start_flash = 1'b0;
            cyc();
        end
        if (done_cnt - dn0 !== 4 || rd_addr_q.size() - ra0 !== 4) begin
            $display("FAIL loop_counts: done %0d reads %0d want 4 4", done_cnt - dn0, rd_addr_q.size() - ra0);
            n_err++;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (rd_addr_q[ra0+k] !== 23'(32'h10 + k)) begin
                    $display("FAIL loop_addr%0d: got %h want %h", k, rd_addr_q[ra0+k], 23'(32'h10 + k));
                    n_err++;
                end
            end
        end
        n_vec++;
        if (samp_q.size() - sq0 !== 8) begin
            $display("FAIL loop_nsamp: got %0d want 8", samp_q.size() - sq0);
            n_err++;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (samp_q[sq0+k] !== 16'h1000 + 16'(k)) begin
                    $display("FAIL loop_samp%0d: got %h want %h", k, samp_q[sq0+k], 16'h1000 + 16'(k));
                    n_err++;
                end
            end
        end
        n_vec++;
    endtask

    task automatic test_reset_midop();
        int av0;
        flash_waitrequest = 1'b1;
        flash_mem_address = 32'h0000_0300;
        start_flash = 1'b1;
        cyc();
        cyc();
        if (flash_read !== 1'b1) begin
            $display("FAIL midop_pre: read %b want 1", flash_read);
            n_err++;
        end
        n_vec++;
        reset_n = 1'b0;
        #1;
        if (flash_read !== 1'b0 || audio_data !== 16'h0 || busy !== 1'b0 || flash_address !== 23'h0) begin
            $display("FAIL midop_async: read %b data %h busy %b addr %h want 0 0 0 0",
                     flash_read, audio_data, busy, flash_address);
            n_err++;
        end
        n_vec++;
        start_flash = 1'b0;
        flash_waitrequest = 1'b0;
        cyc();
        reset_n = 1'b1;
        av0 = av_cnt;
        cyc();
        flash_readdata = 32'h1111_2222;
        flash_readdatavalid = 1'b1;
        cyc();
        flash_readdatavalid = 1'b0;
        pulse_tick();
        cyc();
        pulse_tick();
        cyc();
        if (av_cnt - av0 !== 0 || busy !== 1'b0 || audio_data !== 16'h0) begin
            $display("FAIL midop_stray: valid count %0d busy %b data %h want 0 0 0", av_cnt - av0, busy, audio_data);
            n_err++;
        end
        n_vec++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_waitrequest();
        test_same_cycle_valid();
        test_early_ticks();
        test_back_to_back();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/flash_sample_reader.md
Name: flash_sample_reader

Overview:
- Downstream stage of the flash address sequencer.
- On each new read request, fetches one 32-bit word from flash over an Avalon-MM read master port and splits it into two 16-bit audio samples, low half first.
- Presents each sample to the audio codec path on successive sample ticks, then pulses audio_done so the sequencer advances the address.

Parameters:
ADDR_WIDTH, 23, width of the flash word address driven to the flash controller
DATA_WIDTH, 32, flash read data width; fixed at 2 x SAMPLE_WIDTH
SAMPLE_WIDTH, 16, width of one audio sample

Ports:
clk  input  1  system clock; single clock domain
reset_n  input  1  asynchronous active-low reset
start_flash  input  1  read request level from sequencer; a read launches on its rising edge
flash_mem_address  input  32  word address from sequencer; only bits [ADDR_WIDTH-1:0] used
sample_tick  input  1  one-cycle strobe at audio sample rate, synchronous to clk
flash_read  output  1  Avalon read strobe
flash_address  output  ADDR_WIDTH  Avalon word address
flash_byteenable  output  4  Avalon byte enables; constant 4'b1111
flash_waitrequest  input  1  Avalon wait request
flash_readdata  input  DATA_WIDTH  Avalon read data
flash_readdatavalid  input  1  Avalon read data valid
audio_data  output  SAMPLE_WIDTH  current sample, held between ticks
audio_valid  output  1  one-cycle pulse when audio_data updates
audio_done  output  1  one-cycle pulse after the high-half sample is presented
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, reset_n=0): state IDLE; flash_read=0; flash_address=0; audio_data=0; audio_valid=0; audio_done=0; busy=0; start_flash edge register=0; word register=0.
- Edge detect: start_q registers start_flash each cycle; launch = start_flash & ~start_q. A launch seen outside IDLE is dropped, never queued.
- States:
  - IDLE: on launch, latch flash_address <= flash_mem_address[ADDR_WIDTH-1:0], go to REQ.
  - REQ: flash_read=1, flash_address held. Leave when flash_waitrequest=0 sampled with flash_read=1.
    - If flash_readdatavalid=1 in that same cycle, latch data and go to WAIT_LO.
    - Otherwise go to WAIT_DATA.
  - WAIT_DATA: flash_read=0. On flash_readdatavalid=1, latch word <= flash_readdata, go to WAIT_LO.
  - WAIT_LO: on sample_tick, audio_data <= word[15:0], audio_valid pulses, go to WAIT_HI.
  - WAIT_HI: on sample_tick, audio_data <= word[31:16], audio_valid pulses, go to DONE.
  - DONE: audio_done=1 for exactly one cycle, go to IDLE.
- sample_tick is honoured only in WAIT_LO and WAIT_HI. Ticks arriving during REQ or WAIT_DATA are discarded; audio_data keeps its last value.
- Timing: the first sample appears on the first tick at least 1 cycle after data latch. audio_data and audio_valid are registered and update the cycle after the tick is sampled. audio_done is asserted the cycle after the high-half audio_valid.
- Extended waitrequest: flash_read and flash_address stay stable for its entire duration; there is no timeout.
- flash_readdatavalid outside REQ and WAIT_DATA is ignored.
- A start_flash rising edge in the same cycle as DONE is dropped. The sequencer drops start_flash for at least one cycle after audio_done, so its next rising edge lands in IDLE.
- Address bits above ADDR_WIDTH are discarded; no wrap logic (the sequencer owns the bounds).
- Reset mid-operation: all outputs return to reset values immediately, including dropping flash_read. Any outstanding flash read data is ignored after reset release because the state is IDLE.

Test Plan:
- Basic read: start_flash rises with addr=0x000100; waitrequest=0 immediately; readdatavalid 3 cycles later with 0xBEEF1234 -> flash_read high exactly 1 cycle with flash_address=0x000100; audio_data=0x1234 after 1st tick, 0xBEEF after 2nd; audio_done one pulse; busy returns to 0.
- Waitrequest stall: waitrequest held high 5 cycles -> flash_read high 6 cycles, address constant; data 0x00FF_FF00 yields samples 0xFF00 then 0x00FF.
- Same-cycle valid: waitrequest=0 and readdatavalid=1 in the same cycle with data 0x5555AAAA -> WAIT_DATA skipped; samples 0xAAAA, 0x5555.
- Early ticks and dropped launch: 3 ticks and a second start_flash rising edge during WAIT_DATA -> no audio_valid and no new read; first audio_valid only on first tick after data latch.
- Sequencer loop: drive start_flash high, low 1 cycle after each audio_done, high again, with incrementing addresses 0x10..0x13 -> 4 reads, 8 samples in order, 4 audio_done pulses, no duplicate read of any address.
- Reset mid-op: assert reset_n=0 during REQ with waitrequest high -> flash_read=0 and audio_data=0 in the same cycle; after release a stray readdatavalid produces no audio_valid.
